// File: rtl/icache_ctrl_pkg.sv
// Shared definitions for the instruction-cache miss controller:
// state encoding and the address field positions.
package icache_ctrl_pkg;

  localparam int ICACHE_OFFSET_BITS = 4;
  localparam int ICACHE_SET_DEPTH   = 5;
  localparam int ICACHE_TAG_WIDTH   = 7;

  // Field LSB positions inside a fetch byte address.
  localparam int ICACHE_OFFSET_LSB  = 0;
  localparam int ICACHE_SET_LSB     = ICACHE_OFFSET_LSB + ICACHE_OFFSET_BITS;
  localparam int ICACHE_TAG_LSB     = ICACHE_SET_LSB + ICACHE_SET_DEPTH;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_REFILL   = 3'd4,
    S_REPLAY   = 3'd5,
    S_FLUSH    = 3'd6
  } state_t;

endpackage

// File: rtl/icache_miss_ctrl.sv
// Instruction-cache miss controller: one fetch at a time, tag lookup one
// cycle after accept, block refill and replay on a miss, and whole-cache
// invalidation serialised behind any miss already in flight.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1; valid and its payload stay stable until then. core_rsp_valid_o
// and mem_rsp_valid_i are single-cycle pulses with no back-pressure.
module icache_miss_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int OFFSET_BITS = ICACHE_OFFSET_BITS,
  parameter int SET_DEPTH   = ICACHE_SET_DEPTH,
  parameter int TAG_WIDTH   = ICACHE_TAG_WIDTH,
  parameter int NUM_WAY     = 2,
  parameter int WAY_DEPTH   = 1,
  parameter int WID_WIDTH   = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          core_req_valid_i,
  output logic                          core_req_ready_o,
  input  logic [ADDR_WIDTH-1:0]         core_req_addr_i,
  input  logic [WID_WIDTH-1:0]          core_req_wid_i,
  output logic                          core_rsp_valid_o,
  output logic [WID_WIDTH-1:0]          core_rsp_wid_o,
  output logic [ADDR_WIDTH-1:0]         core_rsp_addr_o,
  output logic [WAY_DEPTH-1:0]          core_rsp_wayid_o,
  input  logic                          flush_i,
  output logic                          tag_r_req_valid_o,
  output logic [SET_DEPTH-1:0]          tag_r_req_setid_o,
  output logic [TAG_WIDTH-1:0]          tag_tag_st1_o,
  input  logic                          tag_hit_st1_i,
  input  logic [WAY_DEPTH-1:0]          tag_wayid_hit_st1_i,
  output logic                          tag_w_req_valid_o,
  output logic [SET_DEPTH-1:0]          tag_w_req_setid_o,
  output logic [NUM_WAY*TAG_WIDTH-1:0]  tag_w_req_data_o,
  output logic                          tag_invalid_o,
  output logic                          mem_req_valid_o,
  input  logic                          mem_req_ready_i,
  output logic [ADDR_WIDTH-1:0]         mem_req_addr_o,
  input  logic                          mem_rsp_valid_i,
  output logic                          busy_o,
  output logic [2:0]                    dbg_state_o
);

  localparam int SET_LSB = OFFSET_BITS;
  localparam int TAG_LSB = OFFSET_BITS + SET_DEPTH;

  state_t                 state_q, state_d;
  logic                   flush_pending_q;
  logic                   pend_clr;
  logic                   cap_en;
  logic [ADDR_WIDTH-1:0]  cap_addr_q;
  logic [WID_WIDTH-1:0]   cap_wid_q;

  logic [SET_DEPTH-1:0]   cap_set;
  logic [TAG_WIDTH-1:0]   cap_tag;
  logic [ADDR_WIDTH-1:0]  blk_addr;

  assign cap_set  = cap_addr_q[SET_LSB +: SET_DEPTH];
  assign cap_tag  = cap_addr_q[TAG_LSB +: TAG_WIDTH];
  assign blk_addr = {cap_addr_q[ADDR_WIDTH-1:OFFSET_BITS], {OFFSET_BITS{1'b0}}};

  assign core_rsp_wid_o  = cap_wid_q;
  assign core_rsp_addr_o = cap_addr_q;
  assign tag_tag_st1_o   = cap_tag;
  assign busy_o          = (state_q != S_IDLE) || flush_pending_q;
  assign dbg_state_o     = state_q;

  // State register, pending-flush flag and request capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= S_IDLE;
      flush_pending_q <= 1'b0;
      cap_addr_q      <= '0;
      cap_wid_q       <= '0;
    end else begin
      state_q <= state_d;
      // A flush arriving mid-miss waits until the miss has responded.
      if (pend_clr)
        flush_pending_q <= 1'b0;
      else if (flush_i && state_q != S_IDLE && state_q != S_FLUSH)
        flush_pending_q <= 1'b1;
      if (cap_en) begin
        cap_addr_q <= core_req_addr_i;
        cap_wid_q  <= core_req_wid_i;
      end
    end
  end

  // Next-state and output decode; idle values first, each state raises its own.
  always_comb begin
    state_d           = state_q;
    cap_en            = 1'b0;
    pend_clr          = 1'b0;
    core_req_ready_o  = 1'b0;
    core_rsp_valid_o  = 1'b0;
    core_rsp_wayid_o  = '0;
    tag_r_req_valid_o = 1'b0;
    tag_r_req_setid_o = '0;
    tag_w_req_valid_o = 1'b0;
    tag_w_req_setid_o = '0;
    tag_w_req_data_o  = '0;
    tag_invalid_o     = 1'b0;
    mem_req_valid_o   = 1'b0;
    mem_req_addr_o    = '0;
    case (state_q)
      S_IDLE: begin
        if (flush_i || flush_pending_q) begin
          state_d = S_FLUSH;
        end else begin
          core_req_ready_o = 1'b1;
          if (core_req_valid_i) begin
            cap_en            = 1'b1;
            tag_r_req_valid_o = 1'b1;
            tag_r_req_setid_o = core_req_addr_i[SET_LSB +: SET_DEPTH];
            state_d           = S_LOOKUP;
          end
        end
      end
      S_LOOKUP: begin
        if (tag_hit_st1_i) begin
          core_rsp_valid_o = 1'b1;
          core_rsp_wayid_o = tag_wayid_hit_st1_i;
          state_d          = S_IDLE;
        end else begin
          state_d = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        mem_req_valid_o = 1'b1;
        mem_req_addr_o  = blk_addr;
        if (mem_req_ready_i) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_rsp_valid_i) state_d = S_REFILL;
      end
      S_REFILL: begin
        // The tag-access block picks the LRU way; every field carries the tag.
        tag_w_req_valid_o = 1'b1;
        tag_w_req_setid_o = cap_set;
        tag_w_req_data_o  = {NUM_WAY{cap_tag}};
        state_d           = S_REPLAY;
      end
      S_REPLAY: begin
        tag_r_req_valid_o = 1'b1;
        tag_r_req_setid_o = cap_set;
        state_d           = S_LOOKUP;
      end
      S_FLUSH: begin
        tag_invalid_o = 1'b1;
        pend_clr      = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_icache_miss_ctrl.sv
// Bench for icache_miss_ctrl: a behavioural tag array answers the lookup
// port, and a block-level 2-way LRU cache model predicts hit/miss.
module tb_icache_miss_ctrl;
  import icache_ctrl_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        core_req_valid_i, core_req_ready_o;
  logic [31:0] core_req_addr_i;
  logic [2:0]  core_req_wid_i;
  logic        core_rsp_valid_o;
  logic [2:0]  core_rsp_wid_o;
  logic [31:0] core_rsp_addr_o;
  logic        core_rsp_wayid_o;
  logic        flush_i;
  logic        tag_r_req_valid_o;
  logic [4:0]  tag_r_req_setid_o;
  logic [6:0]  tag_tag_st1_o;
  logic        env_hit, env_way;
  logic        tag_w_req_valid_o;
  logic [4:0]  tag_w_req_setid_o;
  logic [13:0] tag_w_req_data_o;
  logic        tag_invalid_o;
  logic        mem_req_valid_o, mem_req_ready_i;
  logic [31:0] mem_req_addr_o;
  logic        mem_rsp_valid_i;
  logic        busy_o;
  logic [2:0]  dbg_state_o;

  icache_miss_ctrl dut (
    .clk(clk), .rst(rst),
    .core_req_valid_i(core_req_valid_i), .core_req_ready_o(core_req_ready_o),
    .core_req_addr_i(core_req_addr_i), .core_req_wid_i(core_req_wid_i),
    .core_rsp_valid_o(core_rsp_valid_o), .core_rsp_wid_o(core_rsp_wid_o),
    .core_rsp_addr_o(core_rsp_addr_o), .core_rsp_wayid_o(core_rsp_wayid_o),
    .flush_i(flush_i),
    .tag_r_req_valid_o(tag_r_req_valid_o), .tag_r_req_setid_o(tag_r_req_setid_o),
    .tag_tag_st1_o(tag_tag_st1_o),
    .tag_hit_st1_i(env_hit), .tag_wayid_hit_st1_i(env_way),
    .tag_w_req_valid_o(tag_w_req_valid_o), .tag_w_req_setid_o(tag_w_req_setid_o),
    .tag_w_req_data_o(tag_w_req_data_o), .tag_invalid_o(tag_invalid_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
    .mem_req_addr_o(mem_req_addr_o), .mem_rsp_valid_i(mem_rsp_valid_i),
    .busy_o(busy_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- checking ----------------
  int n_vec = 0;
  int n_err = 0;
  int mem_hs = 0;
  int exp_hs = 0;
  logic [34:0] exp_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- tag-access environment ----------------
  logic       env_v   [32][2];
  logic [6:0] env_tag [32][2];
  logic       env_lru [32];
  logic       rd_pend;
  logic [4:0] rd_set;
  logic       fill_way;

  always_comb begin
    env_hit = 1'b0;
    env_way = 1'b0;
    if (rd_pend)
      for (int w = 0; w < 2; w++)
        if (env_v[rd_set][w] && env_tag[rd_set][w] == tag_tag_st1_o) begin
          env_hit = 1'b1;
          env_way = w[0];
        end
  end

  always_comb begin
    if (!env_v[tag_w_req_setid_o][0])      fill_way = 1'b0;
    else if (!env_v[tag_w_req_setid_o][1]) fill_way = 1'b1;
    else                                   fill_way = env_lru[tag_w_req_setid_o];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend <= 1'b0;
      rd_set  <= '0;
      for (int s = 0; s < 32; s++) begin
        env_v[s][0] <= 1'b0;
        env_v[s][1] <= 1'b0;
        env_lru[s]  <= 1'b0;
      end
    end else begin
      rd_pend <= tag_r_req_valid_o;
      rd_set  <= tag_r_req_setid_o;
      if (rd_pend && env_hit) env_lru[rd_set] <= ~env_way;
      if (tag_w_req_valid_o) begin
        env_v[tag_w_req_setid_o][fill_way]   <= 1'b1;
        env_tag[tag_w_req_setid_o][fill_way] <= tag_w_req_data_o[6:0];
        env_lru[tag_w_req_setid_o]           <= ~fill_way;
      end
      if (tag_invalid_o)
        for (int s = 0; s < 32; s++) begin
          env_v[s][0] <= 1'b0;
          env_v[s][1] <= 1'b0;
        end
    end
  end

  // ---------------- reference cache model ----------------
  // Residency per 12-bit block id {tag,set}; nonzero stamp = resident,
  // larger stamp = more recently used. Two blocks per set at most.
  int unsigned stamp [4096];
  int unsigned now_t = 0;

  function automatic logic [11:0] blk_of(input logic [31:0] a);
    return {a[ICACHE_TAG_LSB +: 7], a[ICACHE_SET_LSB +: 5]};
  endfunction

  function automatic bit model_hit(input logic [31:0] a);
    return stamp[blk_of(a)] != 0;
  endfunction

  task automatic model_touch(input logic [31:0] a);
    logic [11:0] blk, idx, victim;
    int cnt;
    int unsigned oldest;
    blk = blk_of(a);
    now_t++;
    if (stamp[blk] == 0) begin
      cnt = 0; oldest = '1; victim = '0;
      for (int t = 0; t < 128; t++) begin
        idx = {t[6:0], blk[4:0]};
        if (stamp[idx] != 0) begin
          cnt++;
          if (stamp[idx] < oldest) begin oldest = stamp[idx]; victim = idx; end
        end
      end
      if (cnt >= 2) stamp[victim] = 0;
    end
    stamp[blk] = now_t;
  endtask

  task automatic model_clear();
    foreach (stamp[i]) stamp[i] = 0;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst) begin
      logic [34:0] e;
      if (core_rsp_valid_o || exp_q.size() != 0)
        if (core_rsp_valid_o) begin
          check("rsp_expected", core_rsp_valid_o, exp_q.size() != 0);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("rsp_wid", core_rsp_wid_o, e[34:32]);
            check("rsp_addr", core_rsp_addr_o, e[31:0]);
            check("rsp_way", core_rsp_wayid_o, env_way);
          end
        end
      if (tag_w_req_valid_o || tag_invalid_o)
        check("w_inv_excl", tag_w_req_valid_o & tag_invalid_o, 0);
      if (mem_req_valid_o && mem_req_ready_i) mem_hs++;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string p);
    check({p, "_ready"},   core_req_ready_o, 1);
    check({p, "_rspv"},    core_rsp_valid_o, 0);
    check({p, "_rspwid"},  core_rsp_wid_o, 0);
    check({p, "_rspaddr"}, core_rsp_addr_o, 0);
    check({p, "_rspway"},  core_rsp_wayid_o, 0);
    check({p, "_rd"},      {tag_r_req_valid_o, tag_r_req_setid_o, tag_tag_st1_o}, 0);
    check({p, "_wr"},      {tag_w_req_valid_o, tag_w_req_setid_o, tag_w_req_data_o}, 0);
    check({p, "_inv"},     tag_invalid_o, 0);
    check({p, "_mem"},     {mem_req_valid_o, mem_req_addr_o}, 0);
    check({p, "_busy"},    busy_o, 0);
    check({p, "_state"},   dbg_state_o, 0);
  endtask

  // One fetch from an idle controller, cycle-exact against the timing rules.
  task automatic do_txn(input logic [31:0] addr, input logic [2:0] wid, input int stall,
                        input int dly, input bit flush_mid, input bit rst_mid);
    bit hit;
    logic [31:0] blk_addr;
    hit = model_hit(addr);
    blk_addr = {addr[31:4], 4'h0};
    core_req_valid_i = 1'b1; core_req_addr_i = addr; core_req_wid_i = wid;
    #1;
    check("accept_ready", core_req_ready_o, 1);
    check("rd_valid", tag_r_req_valid_o, 1);
    check("rd_setid", tag_r_req_setid_o, addr[ICACHE_SET_LSB +: 5]);
    next_cyc();                                    // T+1: lookup
    core_req_valid_i = 1'b0;
    if (hit) begin exp_q.push_back({wid, addr}); model_touch(addr); end
    #1;
    check("lookup_tag", tag_tag_st1_o, addr[ICACHE_TAG_LSB +: 7]);
    check("lookup_rsp", core_rsp_valid_o, hit);
    check("lookup_nomem", mem_req_valid_o, 0);
    if (hit) begin
      next_cyc(); #1;                              // T+2: ready again
      check("hit_ready", core_req_ready_o, 1);
      check("hit_nomem", mem_req_valid_o, 0);
      return;
    end
    next_cyc();                                    // T+2: memory request
    for (int i = 0; i <= stall; i++) begin
      mem_req_ready_i = (i == stall);
      mem_rsp_valid_i = (i < stall) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (i == stall) exp_hs++;
      #1;
      check("mem_valid", mem_req_valid_o, 1);
      check("mem_addr", mem_req_addr_o, blk_addr);
      check("mem_nowr", tag_w_req_valid_o, 0);
      next_cyc();
    end
    mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0; flush_i = flush_mid;
    #1;                                            // first wait cycle
    check("wait_memv", mem_req_valid_o, 0);
    check("wait_busy", busy_o, 1);
    if (rst_mid) begin
      rst = 1'b1; flush_i = 1'b0;
      #1;
      check_idle_outputs("rst");
      model_clear();
      next_cyc();
      rst = 1'b0; mem_rsp_valid_i = 1'b1;          // late response, dropped
      next_cyc();
      mem_rsp_valid_i = 1'b0;
      #1;
      check("late_rsp_nowr", tag_w_req_valid_o, 0);
      check("late_rsp_ready", core_req_ready_o, 1);
      return;
    end
    for (int i = 0; i < dly; i++) begin
      next_cyc(); flush_i = 1'b0; #1;
      check("wait_nowr", tag_w_req_valid_o, 0);
    end
    next_cyc(); flush_i = 1'b0; mem_rsp_valid_i = 1'b1;   // R
    next_cyc(); mem_rsp_valid_i = 1'b0; #1;                // R+1
    check("refill_wv", tag_w_req_valid_o, 1);
    check("refill_set", tag_w_req_setid_o, addr[ICACHE_SET_LSB +: 5]);
    check("refill_data", tag_w_req_data_o, {2{addr[ICACHE_TAG_LSB +: 7]}});
    next_cyc(); #1;                                        // R+2
    check("replay_rv", tag_r_req_valid_o, 1);
    check("replay_set", tag_r_req_setid_o, addr[ICACHE_SET_LSB +: 5]);
    check("replay_nowr", tag_w_req_valid_o, 0);
    exp_q.push_back({wid, addr});
    model_touch(addr);
    next_cyc(); #1;                                        // R+3
    check("miss_rsp", core_rsp_valid_o, 1);
    next_cyc(); #1;                                        // R+4
    check("post_ready", core_req_ready_o, !flush_mid);
    check("post_busy", busy_o, flush_mid);
    if (flush_mid) begin
      next_cyc(); #1;
      check("pend_inv", tag_invalid_o, 1);
      check("pend_ready", core_req_ready_o, 0);
      model_clear();
      next_cyc(); #1;
      check("pend_done", {core_req_ready_o, tag_invalid_o}, 2'b10);
    end
  endtask

  // Flush and a fetch presented together: flush wins, fetch follows.
  task automatic do_flush_req(input logic [31:0] addr, input logic [2:0] wid);
    flush_i = 1'b1; core_req_valid_i = 1'b1; core_req_addr_i = addr; core_req_wid_i = wid;
    #1;
    check("fr_ready", core_req_ready_o, 0);
    check("fr_nord", tag_r_req_valid_o, 0);
    next_cyc();
    flush_i = 1'b0;
    #1;
    check("fr_inv", tag_invalid_o, 1);
    check("fr_ready2", core_req_ready_o, 0);
    model_clear();
    next_cyc();
    do_txn(addr, wid, 0, 1, 1'b0, 1'b0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] r, addr;
    int kind, tg, st;
    rst = 1'b1;
    core_req_valid_i = 1'b0; core_req_addr_i = '0; core_req_wid_i = '0;
    flush_i = 1'b0; mem_req_ready_i = 1'b0; mem_rsp_valid_i = 1'b0;
    #2;
    check_idle_outputs("reset");
    repeat (3) @(posedge clk);
    #1; rst = 1'b0;
    next_cyc();

    do_txn(32'h0000_0230, 3'd5, 0, 2, 1'b0, 1'b0);   // cold miss
    do_txn(32'h0000_0230, 3'd6, 0, 0, 1'b0, 1'b0);   // hit
    do_txn(32'h0000_1458, 3'd1, 5, 1, 1'b0, 1'b0);   // back-pressure
    do_txn(32'h0000_2670, 3'd2, 1, 3, 1'b1, 1'b0);   // flush during wait
    do_txn(32'h0000_0230, 3'd3, 0, 0, 1'b0, 1'b0);   // misses after flush
    do_flush_req(32'h0000_0234, 3'd4);
    do_txn(32'h0000_0234, 3'd4, 0, 0, 1'b0, 1'b0);   // hit after refill
    do_txn(32'h0000_3a50, 3'd7, 2, 2, 1'b0, 1'b1);   // reset mid-miss

    for (int n = 0; n < 160; n++) begin
      r  = $urandom();
      tg = $urandom_range(0, 2);
      st = $urandom_range(0, 3);
      addr = {r[31:16], tg[6:0], st[4:0], r[3:0]};
      kind = $urandom_range(0, 15);
      if (kind == 0) do_flush_req(addr, r[6:4]);
      else do_txn(addr, r[6:4], $urandom_range(0, 4), $urandom_range(0, 3),
                  kind == 1 || kind == 2, kind == 3);
      repeat ($urandom_range(0, 2)) next_cyc();
    end

    next_cyc(); next_cyc();
    check("mem_hs_total", mem_hs, exp_hs);
    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
